result_dispatch: RTL and testbench

//  Inverse of the 5:1 ALU-operand select path: takes one 32-bit datapath result plus a 3-bit

---
 rtl/dispatch_pkg.sv | 25 ++
 rtl/dispatch_fifo.sv | 64 ++++++
 rtl/result_dispatch.sv | 140 ++++++++++++++
 tb/tb_result_dispatch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared destination codes, payload layout and FSM states for result_dispatch.
package dispatch_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned NUM_DST = 5;

  localparam logic [SEL_W-1:0] DST_B   = SEL_W'(0);
  localparam logic [SEL_W-1:0] DST_EXT = SEL_W'(1);
  localparam logic [SEL_W-1:0] DST_R4  = SEL_W'(2);
  localparam logic [SEL_W-1:0] DST_R1  = SEL_W'(3);
  localparam logic [SEL_W-1:0] DST_MEM = SEL_W'(4);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Small power-of-two FIFO holding {sel,data} words ahead of the dispatch FSM.
// full/empty are registered; rdata_c is the combinational head entry.
module dispatch_fifo #(
  parameter int unsigned W     = 35,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata_c,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata_c = mem[rd_ptr];

  // Occupancy update for a push, a pop, or both in one cycle
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/result_dispatch.sv
// Steers one result word to one of five sinks via one-hot load enables.
// Sinks 0-3 load in one cycle; sink 4 (memory) waits for mem_ack or times out.
// Optional build macro DISPATCH_CNT_EN adds the dispatch_cnt delivery counter.
module result_dispatch
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [DATA_W-1:0]  in_data,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_DST-1:0] load_en,
  input  logic               mem_ack,
  output logic               busy,
  output logic               err
`ifdef DISPATCH_CNT_EN
  ,
  output logic [15:0]        dispatch_cnt
`endif
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  out_data_nxt;
  logic [NUM_DST-1:0] load_en_nxt;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nxt;
  logic               err_nxt;
  logic               pop_c;
  logic               full;
  logic               empty;
  word_t              in_word;
  word_t              head;

  assign in_word  = '{sel: in_sel, data: in_data};
  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

  dispatch_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (pop_c),
    .wdata   (in_word),
    .rdata_c (head),
    .full    (full),
    .empty   (empty)
  );

  // Next-state and output decode; pops happen only from IDLE
  always_comb begin
    state_nxt    = state;
    out_data_nxt = out_data;
    load_en_nxt  = load_en;
    timer_nxt    = timer;
    err_nxt      = err;
    pop_c        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop_c        = 1'b1;
          out_data_nxt = head.data;
          timer_nxt    = '0;
          if (head.sel < SEL_W'(NUM_DST)) begin
            load_en_nxt = NUM_DST'(1) << head.sel;
            state_nxt   = (head.sel == DST_MEM) ? WAIT_ACK : LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        load_en_nxt = '0;
        state_nxt   = IDLE;
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          load_en_nxt = '0;
          state_nxt   = IDLE;
        end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
          load_en_nxt = '0;
          err_nxt     = 1'b1;
          timer_nxt   = '0;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: begin
        load_en_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= '0;
      load_en  <= '0;
      timer    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_data <= out_data_nxt;
      load_en  <= load_en_nxt;
      timer    <= timer_nxt;
      err      <= err_nxt;
    end
  end

`ifdef DISPATCH_CNT_EN
  logic        delivered_c;
  logic [15:0] dispatch_cnt_nxt;

  // A delivery completes on LOAD exit or on an acknowledged memory write
  always_comb begin
    delivered_c      = (state == LOAD) || ((state == WAIT_ACK) && mem_ack);
    dispatch_cnt_nxt = dispatch_cnt + 16'(delivered_c);
  end

  // Delivery counter register, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dispatch_cnt <= '0;
    else       dispatch_cnt <= dispatch_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_result_dispatch.sv
// Bench for result_dispatch: directed scenarios plus randomized traffic against
// a transaction-level model (ordered queue of accepted words, per-word ack delay).
module tb_result_dispatch;
  import dispatch_pkg::*;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = 3'd0;
  logic [31:0] in_data = 32'd0;
  logic [31:0] out_data;
  logic [4:0]  load_en;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        err;
`ifdef DISPATCH_CNT_EN
  logic [15:0] dispatch_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  exp_t        cur;
  exp_t        dummy;
  bit          cur_valid = 1'b0;
  bit          exp_err = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  bit          mon_en = 1'b0;
  bit          noise_en = 1'b0;
  int          fixed_k = 0;
  int          ack_k = 0;
  int          run_len = 0;

  result_dispatch #(.DEPTH(2), .ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_data (out_data),
    .load_en  (load_en),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .err      (err)
`ifdef DISPATCH_CNT_EN
    ,
    .dispatch_cnt (dispatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Transaction monitor and memory responder: each nonzero load_en run is one delivery
  always @(negedge clk) begin
    logic [4:0] want_le;
    int         explen;
    if (reset || !mon_en) begin
      run_len   = 0;
      cur_valid = 1'b0;
      mem_ack   = 1'b0;
    end else if (load_en != 5'd0) begin
      if (run_len == 0) begin
        while (exp_q.size() > 0 && exp_q[0].sel > 3'd4) begin
          dummy   = exp_q.pop_front();
          exp_err = 1'b1;
        end
        if (exp_q.size() == 0) begin
          check("spurious_load", 32'(load_en), 32'd0);
          cur_valid = 1'b0;
        end else begin
          cur       = exp_q.pop_front();
          cur_valid = 1'b1;
          want_le   = 5'd1 << cur.sel;
          check("load_en", 32'(load_en), 32'(want_le));
          check("out_data", out_data, cur.data);
          ack_k = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, 18));
        end
      end else if (cur_valid) begin
        check("held_data", out_data, cur.data);
      end
      mem_ack = load_en[4] && (run_len == ack_k);
      run_len++;
    end else begin
      if (run_len > 0 && cur_valid) begin
        if (cur.sel != 3'd4) explen = 1;
        else explen = (ack_k < 15) ? ack_k + 1 : 15;
        check("run_len", 32'(run_len), 32'(explen));
        if (cur.sel == 3'd4 && ack_k >= 15) exp_err = 1'b1;
        else exp_cnt = exp_cnt + 16'd1;
      end
      run_len   = 0;
      cur_valid = 1'b0;
      mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Offer one word; returns at the negedge after the accepting edge
  task automatic push(input logic [2:0] s, input logic [31:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    exp_q.push_back('{sel: s, data: d});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the block to go idle and reconcile the model
  task automatic drain();
    int g = 0;
    @(negedge clk);
    while (busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].sel > 3'd4) begin
      dummy   = exp_q.pop_front();
      exp_err = 1'b1;
    end
    check("lost_words", 32'(exp_q.size()), 32'd0);
    check("err_model", 32'(err), 32'(exp_err));
`ifdef DISPATCH_CNT_EN
    check("dispatch_cnt", 32'(dispatch_cnt), 32'(exp_cnt));
`endif
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_cnt = 16'd0;
  endtask

  initial begin
    int g;
    // Reset values while reset is held
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset asserted mid-WAIT_ACK clears outputs without a clock edge
    fixed_k = 100;
    push(3'd4, 32'hCAFE0001);
    g = 0;
    while (!load_en[4] && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("wait_ack_entry", 32'(load_en), 32'h10);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_load_en", 32'(load_en), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_cnt = 16'd0;
    mon_en  = 1'b1;

    // Register sink: one-cycle pulse, one cycle after the push edge
    fixed_k = 0;
    push(3'd3, 32'hDEADBEEF);
    check("lat_early", 32'(load_en), 32'd0);
    @(negedge clk);
    check("r1_pulse", 32'(load_en), 32'h08);
    check("r1_data", out_data, 32'hDEADBEEF);
    @(negedge clk);
    check("r1_width", 32'(load_en), 32'd0);
    drain();

    // Memory sink acked after 3 wait cycles
    fixed_k = 3;
    push(3'd4, 32'h00001234);
    drain();
    check("ack_err", 32'(err), 32'd0);

    // Memory sink never acked: timeout sets sticky err
    fixed_k = 100;
    push(3'd4, 32'h00005678);
    drain();
    check("timeout_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    // Illegal code then a legal word
    reset_dut();
    push(3'd6, 32'h66666666);
    push(3'd0, 32'h0BADF00D);
    drain();
    check("illegal_err", 32'(err), 32'd1);

    // Back-to-back memory words fill the buffer
    reset_dut();
    fixed_k = 3;
    push(3'd4, 32'hA0000001);
    push(3'd4, 32'hA0000002);
    push(3'd4, 32'hA0000003);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Randomized traffic with random ack delays and ack noise
    reset_dut();
    fixed_k  = -1;
    noise_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push(3'($urandom_range(0, 7)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    noise_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
